mem_queue_write_arbiter: RTL and testbench
==========================================

Name: mem_queue_write_arbiter

Overview:
- Shares the single mem-queue write port (mem_we_1 / mem_read_num_1 / mem_addr_1 / mem_data_1) of the curr/mem RAM block between NUM_REQ SMEM pipeline lanes.
- Owns per-read slot allocation: keeps a MEM-count table per read number and hands out the next slot index on each accepted write.
- On a lane's "read done" beat, emits the mem_size_valid / mem_size / mem_size_read_num update toward the RAM block.
- Sits between the SMEM lanes and the RAM block.

Parameters:
- NUM_REQ, 4, number of requesting lanes.
- READ_NUM_WIDTH, 6, read-number width.
- MAX_READ, 64, reads per batch; count-table depth.
- READ_MAX_MEM, 40, slots per read in the mem queue.
- DATA_WIDTH, 256, mem entry width: [p_info, p_x2, p_x1, p_x0].

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  global pipeline stall.
- batch_clear  in  1  pulse; re-initialise the count table.
- clear_busy  out  1  table sweep in progress.
- req_valid  in  NUM_REQ  per-lane request.
- req_ready  out  NUM_REQ  per-lane accept (one-hot or zero).
- req_done  in  NUM_REQ  beat is "read finished", no data.
- req_read_num  in  NUM_REQ*READ_NUM_WIDTH  lane i at slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  lane i at slice i.
- mem_we_1  out  1  write strobe to mem queue.
- mem_read_num_1  out  READ_NUM_WIDTH  write read number.
- mem_addr_1  out  7  slot index within the read.
- mem_data_1  out  DATA_WIDTH  entry.
- mem_size_valid  out  1  size update strobe.
- mem_size  out  7  final MEM count of the read.
- mem_size_read_num  out  READ_NUM_WIDTH  read number for the size update.
- overflow  out  1  sticky: an entry was dropped.

Behaviour:
- FSM states CLEAR and RUN.
- reset_n=0: state CLEAR, clear index 0, rr pointer 0. All outputs 0: mem_we_1, mem_size_valid, overflow, req_ready, data/address outputs. clear_busy=1.
- CLEAR:
  - Writes 0 to cnt[idx], one entry per cycle, regardless of stall.
  - req_ready=0 throughout.
  - After idx==MAX_READ-1, goes to RUN the next cycle. Total MAX_READ cycles.
  - batch_clear in CLEAR restarts idx at 0.
- RUN:
  - batch_clear goes to CLEAR. Same-cycle requests are not granted. overflow clears.
- Grant:
  - In RUN with stall=0, the round-robin arbiter grants one valid lane per cycle.
  - Search starts at the rr pointer. The pointer moves to winner+1 (mod NUM_REQ) after each grant.
  - req_ready is combinational, one-hot to the winner. A handshake is valid&ready.
  - stall=1: req_ready=0, no grant, pointer holds. Outputs strobes drop to 0 the next cycle.
- Accepted data beat (req_done=0), c=cnt[rn]:
  - c<READ_MAX_MEM: next cycle mem_we_1=1, mem_read_num_1=rn, mem_addr_1=c, mem_data_1=data; cnt[rn]<=c+1.
  - c==READ_MAX_MEM: beat is consumed but dropped. mem_we_1=0, overflow<=1 (sticky until reset/batch_clear), cnt unchanged.
- Accepted done beat:
  - Next cycle mem_size_valid=1, mem_size=cnt[rn], mem_size_read_num=rn.
  - cnt[rn]<=0. A read with no entries reports 0.
- Latency: exactly 1 cycle from handshake to strobe. Strobes are single-cycle pulses. The write and size outputs hold their last value when the strobe is low.
- Back-to-back accepts to the same rn must use the updated count: consecutive beats get addr c, c+1. The table is read combinationally or forwarded.
- Data and done beats for the same rn on consecutive cycles: the size reflects all prior accepted writes.
- Arithmetic: counts are 7-bit unsigned, never exceeding READ_MAX_MEM.
- mem_read_num_1 × READ_MAX_MEM addressing is done downstream; this block outputs only the slot index.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds stat_writes (16 bit, accepted-and-written entries) and stat_drops (16 bit, dropped entries) outputs.
  - Both saturate at 0xFFFF.
  - Both clear on reset and batch_clear.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package smem_pkg: READ_NUM_WIDTH, MAX_READ, READ_LEN, READ_MAX_MEM, MEM_QUEUE_ADDR_WIDTH, CURR_QUEUE_ADDR_WIDTH, and the FSM state enum {CLEAR, RUN}.
- One sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, advance enable. Outputs: one-hot grant and grant index, with internal pointer.

Test Plan:
- Reset, then idle → clear_busy high 64 cycles then 0. Any req_valid during the sweep sees req_ready=0. No strobes.
- Lane0 writes read 5 three times, then done → mem_we_1 with addr 0,1,2 on consecutive cycles. Then mem_size_valid with mem_size=3, mem_size_read_num=5. cnt[5] returns to 0.
- All 4 lanes valid continuously, each to a different read → grants cycle 0,1,2,3,0… Each lane gets 1 in every 4 cycles. Stall=1 for 2 cycles freezes grants and the pointer, and the sequence then resumes where it stopped.
- 41 writes to read 7, then done → 40 writes with addr 0..39. The 41st is dropped and overflow=1. mem_size=40.
- Done on read 9 with no writes → mem_size_valid, mem_size=0.
- batch_clear mid-traffic → ready drops the same cycle, 64-cycle sweep, overflow clears. The next write to a previously used read gets addr 0.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared SMEM definitions: read/queue geometry, count width and the
// write-arbiter FSM state encoding.
package smem_pkg;

    localparam int READ_NUM_WIDTH        = 6;
    localparam int MAX_READ              = 64;
    localparam int READ_LEN              = 101;
    localparam int READ_MAX_MEM          = 40;
    localparam int CNT_W                 = 7;
    localparam int MEM_QUEUE_ADDR_WIDTH  = $clog2(MAX_READ * READ_MAX_MEM);
    localparam int CURR_QUEUE_ADDR_WIDTH = $clog2(MAX_READ * READ_LEN);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int               cand;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        // NOTE: every signal gets a default before the search so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr_q) + off) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Pointer moves to winner+1 only when a grant is actually taken.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_queue_write_arbiter.sv
// Shares the mem-queue write port between NUM_REQ SMEM lanes, allocates
// per-read slot indices from a count table and reports final sizes on
// "read done" beats. Optional MEM_ARB_STATS_EN adds write/drop counters.
module mem_queue_write_arbiter
    import smem_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int RN_W       = READ_NUM_WIDTH,
    parameter int N_READ     = MAX_READ,
    parameter int SLOTS      = READ_MAX_MEM,
    parameter int DATA_WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       batch_clear,
    output logic                       clear_busy,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_done,
    input  logic [NUM_REQ*RN_W-1:0]    req_read_num,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                       mem_we_1,
    output logic [RN_W-1:0]            mem_read_num_1,
    output logic [CNT_W-1:0]           mem_addr_1,
    output logic [DATA_WIDTH-1:0]      mem_data_1,
    output logic                       mem_size_valid,
    output logic [CNT_W-1:0]           mem_size,
    output logic [RN_W-1:0]            mem_size_read_num,
    output logic                       overflow
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]                stat_writes,
    output logic [15:0]                stat_drops
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CLR_W = $clog2(N_READ);

    arb_state_e         state_q, state_d;
    logic [CLR_W-1:0]   clr_idx_q;
    logic [CNT_W-1:0]   cnt_q [N_READ];
    logic               grant_en;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               hs;
    logic [RN_W-1:0]    sel_rn;
    logic [DATA_WIDTH-1:0] sel_data;
    logic               sel_done;
    logic [CNT_W-1:0]   cur_cnt;
    logic               slot_full;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= CLEAR;
        else          state_q <= state_d;
    end

    // Next state, sweep flag and grant enable.
    always_comb begin
        state_d    = state_q;
        clear_busy = (state_q == CLEAR) || !reset_n;
        grant_en   = (state_q == RUN) && reset_n && !stall && !batch_clear;
        case (state_q)
            CLEAR: if (!batch_clear && clr_idx_q == CLR_W'(N_READ - 1)) state_d = RUN;
            RUN:   if (batch_clear) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Sweep index: counts through the table while clearing, restarts on batch_clear.
    always_ff @(posedge clk) begin
        if (!reset_n || state_q != CLEAR || batch_clear) clr_idx_q <= '0;
        else                                             clr_idx_q <= clr_idx_q + CLR_W'(1);
    end

    assign arb_req = req_valid & {NUM_REQ{grant_en}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (arb_req),
        .advance   (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign hs        = |grant;
    assign sel_rn    = req_read_num[int'(grant_idx) * RN_W +: RN_W];
    assign sel_data  = req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign sel_done  = req_done[grant_idx];
    // Combinational table read: a same-read accept in the next cycle already sees this cycle's update.
    assign cur_cnt   = cnt_q[sel_rn];
    assign slot_full = (cur_cnt >= CNT_W'(SLOTS));

    // Count table: swept to zero in CLEAR, bumped on writes, zeroed on done.
    always_ff @(posedge clk) begin
        // NOTE: the table has no reset branch; reset enters CLEAR, which sweeps every entry before use.
        if (clear_busy) begin
            cnt_q[clr_idx_q] <= '0;
        end else if (hs) begin
            if (sel_done)        cnt_q[sel_rn] <= '0;
            else if (!slot_full) cnt_q[sel_rn] <= cur_cnt + CNT_W'(1);
        end
    end

    // Registered write/size ports: one-cycle strobes, payloads hold between strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_we_1          <= 1'b0;
            mem_read_num_1    <= '0;
            mem_addr_1        <= '0;
            mem_data_1        <= '0;
            mem_size_valid    <= 1'b0;
            mem_size          <= '0;
            mem_size_read_num <= '0;
            overflow          <= 1'b0;
        end else begin
            mem_we_1       <= 1'b0;
            mem_size_valid <= 1'b0;
            if (batch_clear) overflow <= 1'b0;
            if (hs) begin
                if (sel_done) begin
                    mem_size_valid    <= 1'b1;
                    mem_size          <= cur_cnt;
                    mem_size_read_num <= sel_rn;
                end else if (!slot_full) begin
                    mem_we_1       <= 1'b1;
                    mem_read_num_1 <= sel_rn;
                    mem_addr_1     <= cur_cnt;
                    mem_data_1     <= sel_data;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating counters of written and dropped data beats.
    always_ff @(posedge clk) begin
        if (!reset_n || batch_clear) begin
            stat_writes <= '0;
            stat_drops  <= '0;
        end else if (hs && !sel_done) begin
            if (!slot_full && stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
            if (slot_full && stat_drops != 16'hFFFF)   stat_drops  <= stat_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_queue_write_arbiter.sv
// Self-checking bench for mem_queue_write_arbiter: directed scenarios plus
// randomized traffic, all compared against a table/queue-level model.
module tb_mem_queue_write_arbiter;

    localparam int N  = 4;
    localparam int RW = 6;
    localparam int DW = 256;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            stall;
    logic            batch_clear;
    logic            clear_busy;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_done;
    logic [N*RW-1:0] req_read_num;
    logic [N*DW-1:0] req_data;
    logic            mem_we_1;
    logic [RW-1:0]   mem_read_num_1;
    logic [6:0]      mem_addr_1;
    logic [DW-1:0]   mem_data_1;
    logic            mem_size_valid;
    logic [6:0]      mem_size;
    logic [RW-1:0]   mem_size_read_num;
    logic            overflow;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]     stat_writes;
    logic [15:0]     stat_drops;
`endif

    always #5 clk = ~clk;

    mem_queue_write_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall             (stall),
        .batch_clear       (batch_clear),
        .clear_busy        (clear_busy),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_done          (req_done),
        .req_read_num      (req_read_num),
        .req_data          (req_data),
        .mem_we_1          (mem_we_1),
        .mem_read_num_1    (mem_read_num_1),
        .mem_addr_1        (mem_addr_1),
        .mem_data_1        (mem_data_1),
        .mem_size_valid    (mem_size_valid),
        .mem_size          (mem_size),
        .mem_size_read_num (mem_size_read_num),
        .overflow          (overflow)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_writes       (stat_writes),
        .stat_drops        (stat_drops)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-read counts, rr pointer, remaining sweep cycles, expected outputs.
    int            cnt_m [64];
    int            rr_m;
    int            sweep_m;
    logic          e_we, e_sv, e_ovf;
    logic [RW-1:0] e_rn, e_srn;
    logic [6:0]    e_addr, e_size;
    logic [DW-1:0] e_data;
    logic [N-1:0]  x_ready, obs_ready;
    logic          x_busy, obs_busy;

    function automatic logic [28:0] dut_ctl();
        return {mem_we_1, mem_read_num_1, mem_addr_1, mem_size_valid, mem_size, mem_size_read_num, overflow};
    endfunction

    function automatic logic [28:0] mdl_ctl();
        return {e_we, e_rn, e_addr, e_sv, e_size, e_srn, e_ovf};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        foreach (cnt_m[i]) cnt_m[i] = 0;
        rr_m = 0; sweep_m = 64;
        e_we = 0; e_sv = 0; e_ovf = 0; e_rn = '0; e_srn = '0;
        e_addr = '0; e_size = '0; e_data = '0;
    endtask

    task automatic model_pre();
        x_busy  = (sweep_m > 0);
        x_ready = '0;
        if (sweep_m == 0 && !stall && !batch_clear) begin
            for (int k = 0; k < N; k++) begin
                int l;
                l = (rr_m + k) % N;
                if (req_valid[l]) begin
                    x_ready[l] = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic model_post();
        e_we = 0; e_sv = 0;
        if (sweep_m > 0) begin
            if (batch_clear) begin sweep_m = 64; e_ovf = 0; end
            else sweep_m--;
        end else if (batch_clear) begin
            sweep_m = 64; e_ovf = 0;
            foreach (cnt_m[i]) cnt_m[i] = 0;
        end else if (x_ready != '0) begin
            int w, rn;
            w = 0;
            for (int l = 0; l < N; l++) if (x_ready[l]) w = l;
            rn = int'(req_read_num[w*RW +: RW]);
            if (req_done[w]) begin
                e_sv = 1; e_size = 7'(cnt_m[rn]); e_srn = 6'(rn); cnt_m[rn] = 0;
            end else if (cnt_m[rn] < 40) begin
                e_we = 1; e_rn = 6'(rn); e_addr = 7'(cnt_m[rn]);
                e_data = req_data[w*DW +: DW]; cnt_m[rn]++;
            end else begin
                e_ovf = 1;
            end
            rr_m = (w + 1) % N;
        end
    endtask

    // One clock: inputs already applied at the falling edge; returns at the next falling edge.
    task automatic tick();
        model_pre();
        #2;
        obs_ready = req_ready;
        obs_busy  = clear_busy;
        @(posedge clk);
        model_post();
        #1;
        @(negedge clk);
    endtask

    task automatic set_lane(input int l, input int rn, input logic done);
        req_read_num[l*RW +: RW] = 6'(rn);
        req_done[l]              = done;
        req_data[l*DW +: DW]     = rand_data();
    endtask

    task automatic test_reset();
        int busy_cycles;
        reset_n = 0; stall = 0; batch_clear = 0; req_done = '0;
        for (int l = 0; l < N; l++) set_lane(l, 30 + l, 1'b0);
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'($urandom);
            #2;
            if (k > 0) begin
                checks++;
                if (req_ready !== '0 || clear_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_hs cyc=%0d ready=%b busy=%b want ready=0 busy=1", k, req_ready, clear_busy);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (dut_ctl() !== '0 || mem_data_1 !== '0) begin
                errors++;
                $display("FAIL reset_out cyc=%0d ctl=%h want 0", k, dut_ctl());
            end
            @(negedge clk);
        end
        reset_n = 1;
        model_reset();
        busy_cycles = 0;
        for (int k = 0; k < 70; k++) begin
            req_valid = (k < 64) ? 4'($urandom) : '0;
            stall     = ($urandom_range(0, 3) == 0);
            tick();
            if (obs_busy) busy_cycles++;
            checks++;
            if (obs_ready !== x_ready || obs_busy !== x_busy) begin
                errors++;
                $display("FAIL sweep_hs cyc=%0d ready=%b busy=%b want %b %b", k, obs_ready, obs_busy, x_ready, x_busy);
            end
            checks++;
            if (dut_ctl() !== mdl_ctl()) begin
                errors++;
                $display("FAIL sweep_out cyc=%0d ctl=%h want %h", k, dut_ctl(), mdl_ctl());
            end
        end
        stall = 0;
        checks++;
        if (busy_cycles != 64) begin
            errors++;
            $display("FAIL sweep_len got=%0d want=64", busy_cycles);
        end
    endtask

    task automatic test_seq_writes();
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            set_lane(0, 5, i >= 3);
            tick();
            checks++;
            if (obs_ready !== x_ready || dut_ctl() !== mdl_ctl() || mem_data_1 !== e_data) begin
                errors++;
                $display("FAIL seq_model i=%0d ready=%b ctl=%h want %b %h", i, obs_ready, dut_ctl(), x_ready, mdl_ctl());
            end
            checks++;
            if (i < 3 && (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'(i) || mem_read_num_1 !== 6'd5)) begin
                errors++;
                $display("FAIL seq_addr i=%0d we=%b addr=%0d want we=1 addr=%0d", i, mem_we_1, mem_addr_1, i);
            end else if (i >= 3 && (mem_size_valid !== 1'b1 || mem_size_read_num !== 6'd5
                                    || mem_size !== ((i == 3) ? 7'd3 : 7'd0))) begin
                errors++;
                $display("FAIL seq_size i=%0d sv=%b size=%0d rn=%0d want sv=1 size=%0d rn=5",
                         i, mem_size_valid, mem_size, mem_size_read_num, (i == 3) ? 3 : 0);
            end
        end
        req_valid = '0;
        req_done  = '0;
        tick();
        checks++;
        if (mem_we_1 !== 1'b0 || mem_size_valid !== 1'b0 || dut_ctl() !== mdl_ctl()) begin
            errors++;
            $display("FAIL seq_idle ctl=%h want %h", dut_ctl(), mdl_ctl());
        end
    endtask

    task automatic test_round_robin();
        int exp_lane;
        exp_lane = rr_m;
        req_valid = 4'hF;
        for (int k = 0; k < 14; k++) begin
            for (int l = 0; l < N; l++) set_lane(l, 10 + l, 1'b0);
            stall = (k == 5 || k == 6);
            tick();
            checks++;
            if (stall) begin
                if (obs_ready !== '0 || mem_we_1 !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_stall cyc=%0d ready=%b we=%b want 0 0", k, obs_ready, mem_we_1);
                end
            end else begin
                if (obs_ready !== 4'(1 << exp_lane) || mem_we_1 !== 1'b1 || mem_read_num_1 !== 6'(10 + exp_lane)) begin
                    errors++;
                    $display("FAIL rr_grant cyc=%0d ready=%b rn=%0d want lane %0d", k, obs_ready, mem_read_num_1, exp_lane);
                end
                exp_lane = (exp_lane + 1) % N;
            end
            checks++;
            if (dut_ctl() !== mdl_ctl() || mem_data_1 !== e_data) begin
                errors++;
                $display("FAIL rr_model cyc=%0d ctl=%h want %h", k, dut_ctl(), mdl_ctl());
            end
        end
        stall = 0;
        req_valid = '0;
    endtask

    task automatic test_overflow();
        req_valid = 4'b0100;
        for (int i = 0; i < 42; i++) begin
            set_lane(2, 7, i == 41);
            tick();
            checks++;
            if (dut_ctl() !== mdl_ctl() || obs_ready !== x_ready) begin
                errors++;
                $display("FAIL ovf_model i=%0d ctl=%h want %h", i, dut_ctl(), mdl_ctl());
            end
            checks++;
            if (i < 40 && (mem_we_1 !== 1'b1 || mem_addr_1 !== 7'(i) || overflow !== 1'b0)) begin
                errors++;
                $display("FAIL ovf_addr i=%0d we=%b addr=%0d ovf=%b want 1 %0d 0", i, mem_we_1, mem_addr_1, overflow, i);
            end else if (i == 40 && (mem_we_1 !== 1'b0 || overflow !== 1'b1)) begin
                errors++;
                $display("FAIL ovf_drop we=%b ovf=%b want we=0 ovf=1", mem_we_1, overflow);
            end else if (i == 41 && (mem_size_valid !== 1'b1 || mem_size !== 7'd40 || overflow !== 1'b1)) begin
                errors++;
                $display("FAIL ovf_size sv=%b size=%0d ovf=%b want 1 40 1", mem_size_valid, mem_size, overflow);
            end
        end
        req_valid = '0;
        req_done  = '0;
    endtask

    task automatic test_empty_done();
        req_valid = 4'b1000;
        set_lane(3, 9, 1'b1);
        tick();
        checks++;
        if (mem_size_valid !== 1'b1 || mem_size !== 7'd0 || mem_size_read_num !== 6'd9 || dut_ctl() !== mdl_ctl()) begin
            errors++;
            $display("FAIL empty_done sv=%b size=%0d rn=%0d want 1 0 9", mem_size_valid, mem_size, mem_size_read_num);
        end
        req_valid = '0;
        req_done  = '0;
    endtask

    task automatic test_batch_clear();
        int busy_cycles;
        logic seen_we;
        req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < N; l++) set_lane(l, 10 + l, 1'b0);
            tick();
        end
        batch_clear = 1;
        tick();
        batch_clear = 0;
        checks++;
        if (obs_ready !== '0 || overflow !== 1'b0 || mem_we_1 !== 1'b0) begin
            errors++;
            $display("FAIL bc_cycle ready=%b ovf=%b we=%b want 0 0 0", obs_ready, overflow, mem_we_1);
        end
        busy_cycles = 0;
        seen_we = 0;
        for (int k = 0; k < 66; k++) begin
            tick();
            if (obs_busy) busy_cycles++;
            checks++;
            if (obs_ready !== x_ready || obs_busy !== x_busy || dut_ctl() !== mdl_ctl()) begin
                errors++;
                $display("FAIL bc_model cyc=%0d ready=%b busy=%b ctl=%h want %b %b %h",
                         k, obs_ready, obs_busy, dut_ctl(), x_ready, x_busy, mdl_ctl());
            end
            if (mem_we_1 && !seen_we) begin
                seen_we = 1;
                checks++;
                if (mem_addr_1 !== 7'd0) begin
                    errors++;
                    $display("FAIL bc_addr addr=%0d want 0", mem_addr_1);
                end
            end
        end
        checks++;
        if (busy_cycles != 64 || !seen_we) begin
            errors++;
            $display("FAIL bc_sweep busy=%0d seen_we=%b want 64 1", busy_cycles, seen_we);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid   = 4'($urandom);
            stall       = ($urandom_range(0, 4) == 0);
            batch_clear = ($urandom_range(0, 99) == 0);
            for (int l = 0; l < N; l++) set_lane(l, $urandom_range(0, 7), $urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (obs_ready !== x_ready || obs_busy !== x_busy || dut_ctl() !== mdl_ctl() || mem_data_1 !== e_data) begin
                errors++;
                $display("FAIL rand cyc=%0d ready=%b busy=%b ctl=%h want %b %b %h",
                         k, obs_ready, obs_busy, dut_ctl(), x_ready, x_busy, mdl_ctl());
            end
        end
        stall = 0; batch_clear = 0; req_valid = '0;
    endtask

    initial begin
        reset_n = 0; stall = 0; batch_clear = 0;
        req_valid = '0; req_done = '0; req_read_num = '0; req_data = '0;
        @(negedge clk);
        test_reset();
        test_seq_writes();
        test_round_robin();
        test_overflow();
        test_empty_done();
        test_batch_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
